// File: rtl/imem_loader.sv
// imem_loader: boot-time loader that takes a length-prefixed byte stream and
// packs the payload little-endian into 32-bit instruction memory word writes.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   S_IDLE  | waiting for start after reset
//   S_LEN   | collecting the 4-byte little-endian payload length
//   S_DATA  | collecting payload bytes into the word buffer
//   S_WRITE | one-cycle memory write of the packed word
//   S_DONE  | load finished, done held until the next start
//   S_ERR   | length exceeded capacity, error held until the next start
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] MAX_BYTES = 32'(4 << 20)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [31:0] bytes_written
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_DATA, S_WRITE, S_DONE, S_ERR
  } state_t;

  state_t      state;
  logic [31:0] len_q;
  logic [2:0]  lane;       // lane index in DATA, byte counter in LEN; holds fill count in WRITE
  logic [31:0] word_idx;
  logic [31:0] buf_q;

  logic        xfer;
  logic [31:0] len_full;
  logic [31:0] buf_ins;
  logic [2:0]  fill_nxt;
  logic        last_byte;
  logic [31:0] bw_nxt;

  assign xfer      = in_valid && in_ready;
  assign len_full  = {in_data, len_q[31:8]};
  assign buf_ins   = buf_q | ({24'd0, in_data} << {lane[1:0], 3'b000});
  assign fill_nxt  = lane + 3'd1;
  // Payload bytes of the current word are not yet committed, so add them in.
  assign last_byte = (bytes_written + {29'd0, fill_nxt}) == len_q;
  assign bw_nxt    = bytes_written + {29'd0, lane};

  function automatic logic [3:0] be_mask(input logic [2:0] n);
    case (n)
      3'd1:    be_mask = 4'b0001;
      3'd2:    be_mask = 4'b0011;
      3'd3:    be_mask = 4'b0111;
      default: be_mask = 4'b1111;
    endcase
  endfunction

  // Loader FSM with all outputs registered; write bus defaults to zero each cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      len_q         <= '0;
      lane          <= '0;
      word_idx      <= '0;
      buf_q         <= '0;
      in_ready      <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_be        <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      bytes_written <= '0;
    end else begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state         <= S_LEN;
            len_q         <= '0;
            lane          <= '0;
            word_idx      <= '0;
            buf_q         <= '0;
            bytes_written <= '0;
            in_ready      <= 1'b1;
            busy          <= 1'b1;
            done          <= 1'b0;
            error         <= 1'b0;
          end
        end
        S_LEN: begin
          if (xfer) begin
            len_q <= len_full;
            if (lane == 3'd3) begin
              lane <= '0;
              if (len_full == 32'd0) begin
                state    <= S_DONE;
                in_ready <= 1'b0;
                busy     <= 1'b0;
                done     <= 1'b1;
              end else if (len_full > MAX_BYTES) begin
                state    <= S_ERR;
                in_ready <= 1'b0;
                busy     <= 1'b0;
                error    <= 1'b1;
              end else begin
                state <= S_DATA;
              end
            end else begin
              lane <= fill_nxt;
            end
          end
        end
        S_DATA: begin
          if (xfer) begin
            buf_q <= buf_ins;
            lane  <= fill_nxt;
            if (lane == 3'd3 || last_byte) begin
              state     <= S_WRITE;
              in_ready  <= 1'b0;
              mem_we    <= 1'b1;
              mem_addr  <= BASE_ADDR + (word_idx << 2);
              mem_wdata <= buf_ins;
              mem_be    <= be_mask(fill_nxt);
            end
          end
        end
        S_WRITE: begin
          bytes_written <= bw_nxt;
          word_idx      <= word_idx + 32'd1;
          lane          <= '0;
          buf_q         <= '0;
          if (bw_nxt == len_q) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state    <= S_DATA;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state    <= S_IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: scenario tasks driving length-prefixed byte streams into
// imem_loader and comparing captured word writes against a packing model.
module tb_imem_loader;

  localparam logic [31:0] BASE = 32'h0000_0100;
  localparam logic [31:0] MAXB = 32'(4 << 20);

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [7:0]  lat;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready, mem_we, busy, done, error;
  logic [31:0] mem_addr, mem_wdata, bytes_written;
  logic [3:0]  mem_be;

  int checks = 0;
  int passed = 0;

  wr_t obs[$];
  int  cyc = 0;
  int  last_acc = -100;
  int  bad_ready = 0;
  int  bad_idle = 0;

  imem_loader #(.BASE_ADDR(BASE), .MAX_BYTES(MAXB)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .busy(busy), .done(done), .error(error), .bytes_written(bytes_written)
  );

  always #5 clk = ~clk;

  // Monitor on the falling edge: capture writes with latency and watch invariants.
  initial forever begin
    @(negedge clk);
    cyc++;
    if (mem_we)
      obs.push_back(wr_t'{mem_addr, mem_wdata, mem_be, 8'(cyc - last_acc)});
    else if (mem_addr !== 32'd0 || mem_wdata !== 32'd0 || mem_be !== 4'd0)
      bad_idle++;
    if (busy && !mem_we && !in_ready) bad_ready++;
    if (!busy && in_ready) bad_ready++;
    if (mem_we && in_ready) bad_ready++;
    if (in_valid && in_ready) last_acc = cyc;
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps, output bit ok);
    int n;
    n = gaps ? int'($urandom_range(0, 2)) : 0;
    repeat (n) begin @(posedge clk); #1; end
    in_valid = 1'b1;
    in_data  = b;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic run_load(input string name, input logic [31:0] len, input bq_t pay,
                          input bit gaps, input bit mid_start);
    wr_t exp[$];
    bit  ok;
    int  timeouts;
    logic [31:0] d;
    logic [3:0]  be;
    logic exp_done, exp_err;
    logic [31:0] exp_bw;
    timeouts = 0;
    obs.delete();
    bad_ready = 0;
    bad_idle = 0;
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      send_byte(len[8*i +: 8], gaps, ok);
      if (!ok) timeouts++;
    end
    if (len != 0 && len <= MAXB) begin
      for (int i = 0; i < pay.size(); i++) begin
        if (mid_start && i == 2) pulse_start();
        send_byte(pay[i], gaps, ok);
        if (!ok) timeouts++;
      end
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done || error) break;
    end
    // Reference: chop the payload into 4-byte words, little-endian, tail masked.
    exp_done = 1'b1; exp_err = 1'b0; exp_bw = len;
    if (len > MAXB) begin
      exp_done = 1'b0; exp_err = 1'b1; exp_bw = 32'd0;
    end else begin
      for (int w = 0; w * 4 < int'(len); w++) begin
        d = 32'd0; be = 4'd0;
        for (int k = 0; k < 4; k++)
          if (w * 4 + k < int'(len)) begin
            d[8*k +: 8] = pay[w*4 + k];
            be[k] = 1'b1;
          end
        exp.push_back(wr_t'{BASE + 32'(4 * w), d, be, 8'd1});
      end
    end
    checks++;
    if (timeouts !== 0) $display("FAIL %s stall_timeout got=%0d want=0", name, timeouts);
    else passed++;
    checks++;
    if (obs.size() !== exp.size())
      $display("FAIL %s write_count got=%0d want=%0d", name, obs.size(), exp.size());
    else passed++;
    for (int i = 0; i < exp.size() && i < obs.size(); i++) begin
      checks++;
      if (obs[i] !== exp[i])
        $display("FAIL %s write%0d got addr=%h data=%h be=%b lat=%0d want addr=%h data=%h be=%b lat=%0d",
                 name, i, obs[i].addr, obs[i].data, obs[i].be, obs[i].lat,
                 exp[i].addr, exp[i].data, exp[i].be, exp[i].lat);
      else passed++;
    end
    checks++;
    if ({done, error, busy} !== {exp_done, exp_err, 1'b0})
      $display("FAIL %s status got done=%b err=%b busy=%b want done=%b err=%b busy=0",
               name, done, error, busy, exp_done, exp_err);
    else passed++;
    checks++;
    if (bytes_written !== exp_bw)
      $display("FAIL %s bytes_written got=%0d want=%0d", name, bytes_written, exp_bw);
    else passed++;
    checks++;
    if (bad_ready !== 0 || bad_idle !== 0)
      $display("FAIL %s handshake got ready_viol=%0d bus_viol=%0d want 0/0", name, bad_ready, bad_idle);
    else passed++;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({in_ready, mem_we, mem_addr, mem_wdata, mem_be, busy, done, error, bytes_written} !== '0)
      $display("FAIL reset_outputs got ready=%b we=%b be=%b busy=%b done=%b err=%b bw=%0d want all 0",
               in_ready, mem_we, mem_be, busy, done, error, bytes_written);
    else passed++;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, busy, done, error} !== 4'b0000)
      $display("FAIL idle_after_reset got ready=%b busy=%b done=%b err=%b want 0000",
               in_ready, busy, done, error);
    else passed++;
  endtask

  task automatic test_full_words();
    bq_t p;
    p = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    run_load("len8", 32'd8, p, 1'b0, 1'b0);
  endtask

  task automatic test_tail();
    bq_t p;
    p = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
    run_load("len6_tail", 32'd6, p, 1'b0, 1'b0);
  endtask

  task automatic test_zero_len();
    bq_t p;
    p = {};
    run_load("len0", 32'd0, p, 1'b0, 1'b0);
  endtask

  task automatic test_too_long();
    bq_t p;
    p = {};
    run_load("len_over_max", 32'h0040_0001, p, 1'b0, 1'b0);
    p = '{8'h01, 8'h02, 8'h03, 8'h04};
    run_load("len4_after_err", 32'd4, p, 1'b0, 1'b0);
  endtask

  task automatic test_gaps_mid_start();
    bq_t p;
    p = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    run_load("len8_gaps", 32'd8, p, 1'b1, 1'b1);
  endtask

  task automatic test_max_len_accepted();
    bit ok;
    pulse_start();
    for (int i = 0; i < 4; i++) send_byte(MAXB[8*i +: 8], 1'b0, ok);
    @(negedge clk);
    checks++;
    if ({busy, in_ready, error} !== 3'b110)
      $display("FAIL max_len_accepted got busy=%b ready=%b err=%b want 1 1 0", busy, in_ready, error);
    else passed++;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset_mid_load();
    bit ok;
    logic [31:0] l4;
    l4 = 32'd4;
    obs.delete();
    pulse_start();
    for (int i = 0; i < 4; i++) send_byte(l4[8*i +: 8], 1'b0, ok);
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1'b0, ok);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, mem_we, mem_be, busy, done, error, bytes_written} !== '0)
      $display("FAIL reset_mid_load got ready=%b we=%b be=%b busy=%b done=%b err=%b bw=%0d want all 0",
               in_ready, mem_we, mem_be, busy, done, error, bytes_written);
    else passed++;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (obs.size() !== 0 || done !== 1'b0 || busy !== 1'b0)
      $display("FAIL reset_mid_idle got writes=%0d done=%b busy=%b want 0 0 0", obs.size(), done, busy);
    else passed++;
  endtask

  task automatic test_random_loads();
    bq_t p;
    int  n;
    for (int t = 0; t < 6; t++) begin
      n = int'($urandom_range(1, 13));
      p = {};
      for (int i = 0; i < n; i++) p.push_back(8'($urandom));
      run_load($sformatf("rand%0d_len%0d", t, n), 32'(n), p, 1'b1, t[0]);
    end
  endtask

  initial begin
    test_reset();
    test_full_words();
    test_tail();
    test_zero_len();
    test_too_long();
    test_gaps_mid_start();
    test_max_len_accepted();
    test_reset_mid_load();
    test_random_loads();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
